// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: MSB-first bit-serial unsigned magnitude comparator with a
// start/busy/done handshake and registered equal/greater/lesser result flags.
// Optional feature macro: SERIAL_COMPARE_EARLY_EXIT_EN.
// When it is defined, the compare stops at the first differing bit.
// When it is undefined, the compare always walks all WIDTH positions.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_equal,
  output logic             o_greater,
  output logic             o_lesser
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StDone
  } state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_ra;
  logic [WIDTH-1:0]  r_rb;
  logic [IdxW-1:0]   r_idx;
  logic              r_hit;
  logic              r_equal;
  logic              r_greater;
  logic              r_lesser;

  state_e            w_state_nxt;
  logic [WIDTH-1:0]  w_ra_nxt;
  logic [WIDTH-1:0]  w_rb_nxt;
  logic [IdxW-1:0]   w_idx_nxt;
  logic              w_hit_nxt;
  logic              w_equal_nxt;
  logic              w_greater_nxt;
  logic              w_lesser_nxt;

  logic              w_bit_gt;
  logic              w_bit_lt;
  logic              w_last;

  // Per-bit compare of the current position
  assign w_bit_gt = r_ra[r_idx] & ~r_rb[r_idx];
  assign w_bit_lt = ~r_ra[r_idx] & r_rb[r_idx];
  assign w_last   = (r_idx == '0);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_ra      <= '0;
      r_rb      <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_equal   <= 1'b0;
      r_greater <= 1'b0;
      r_lesser  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ra      <= w_ra_nxt;
      r_rb      <= w_rb_nxt;
      r_idx     <= w_idx_nxt;
      r_hit     <= w_hit_nxt;
      r_equal   <= w_equal_nxt;
      r_greater <= w_greater_nxt;
      r_lesser  <= w_lesser_nxt;
    end
  end

  // Next-state and datapath update; everything holds by default
  always_comb begin
    w_state_nxt   = r_state;
    w_ra_nxt      = r_ra;
    w_rb_nxt      = r_rb;
    w_idx_nxt     = r_idx;
    w_hit_nxt     = r_hit;
    w_equal_nxt   = r_equal;
    w_greater_nxt = r_greater;
    w_lesser_nxt  = r_lesser;

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_ra_nxt      = i_a;
          w_rb_nxt      = i_b;
          w_idx_nxt     = IdxW'(WIDTH - 1);
          w_hit_nxt     = 1'b0;
          w_equal_nxt   = 1'b0;
          w_greater_nxt = 1'b0;
          w_lesser_nxt  = 1'b0;
          w_state_nxt   = StCompare;
        end else if (r_state == StDone) begin
          w_state_nxt = StIdle;
        end
      end

      StCompare: begin
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
        // First differing bit decides; equal only once the LSB matched too
        if (w_bit_gt) begin
          w_greater_nxt = 1'b1;
          w_state_nxt   = StDone;
        end else if (w_bit_lt) begin
          w_lesser_nxt = 1'b1;
          w_state_nxt  = StDone;
        end else if (w_last) begin
          w_equal_nxt = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_idx_nxt = r_idx - IdxW'(1);
        end
`else
        // Fixed latency: r_hit freezes the flags after the first decision
        if (!r_hit) begin
          if (w_bit_gt) begin
            w_greater_nxt = 1'b1;
            w_hit_nxt     = 1'b1;
          end else if (w_bit_lt) begin
            w_lesser_nxt = 1'b1;
            w_hit_nxt    = 1'b1;
          end else if (w_last) begin
            w_equal_nxt = 1'b1;
          end
        end
        if (w_last) begin
          w_state_nxt = StDone;
        end else begin
          w_idx_nxt = r_idx - IdxW'(1);
        end
`endif
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_busy    = (r_state == StCompare);
  assign o_done    = (r_state == StDone);
  assign o_equal   = r_equal;
  assign o_greater = r_greater;
  assign o_lesser  = r_lesser;

endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequential magnitude-compare controller. It latches two WIDTH-bit operands on a start handshake and walks them MSB-first, one bit position per clock. Each step uses 1-bit compare logic (equal/greater/lesser per bit), so a wide compare completes over several cycles instead of needing a wide combinational tree. It sits between a requesting datapath and the result consumer, and reports through a busy/done handshake with registered equal/greater/lesser flags.

## Interface
- WIDTH, 4: operand width in bits; legal range 2 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge of clk; accepted only when state is not COMPARE.
- a  input  WIDTH  operand A; captured on the edge where start is accepted.
- b  input  WIDTH  operand B; captured on the edge where start is accepted.
- busy  output  1  high while state is COMPARE.
- done  output  1  one-cycle pulse, high while state is DONE.
- equal  output  1  registered result: a == b.
- greater  output  1  registered result: a > b (unsigned).
- lesser  output  1  registered result: a < b (unsigned).

## Operation
- States:
  - IDLE (reset state).
  - COMPARE.
  - DONE.
- Internal registers:
  - ra, rb: WIDTH bits each.
  - idx: bit index, $clog2(WIDTH) bits.
  - hit: 1 bit, "decision already made", used only when early exit is compiled out.
- IDLE or DONE, start=1 at an edge:
  - Capture a into ra and b into rb.
  - idx <= WIDTH-1, hit <= 0.
  - Clear equal, greater and lesser to 0.
  - Go to COMPARE.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE after exactly one cycle.
- COMPARE, each edge, examine ra[idx] against rb[idx]:
  - ra[idx]=1, rb[idx]=0: greater <= 1 (a decision).
  - ra[idx]=0, rb[idx]=1: lesser <= 1 (a decision).
  - Bits equal and idx==0 with no decision so far: equal <= 1.
  - Otherwise: idx <= idx-1.
  - Leave COMPARE for DONE on a decision (subject to Configuration) or after idx==0 has been examined.
- Result flags hold their value from the DONE cycle until the next accepted start.
- After the first completed compare, exactly one of equal, greater, lesser is 1.
- start in COMPARE is ignored: no capture, no effect on the compare in progress. The requester must hold or re-issue start.
- The unsigned compare is decided by the most significant differing bit.
- rst_n low at any time, including mid-COMPARE:
  - Immediately state=IDLE.
  - busy, done, equal, greater, lesser, idx and hit all 0.
  - The compare in progress is discarded.

## Timing
- Reset values: busy=0, done=0, equal=0, greater=0, lesser=0.
- Edge numbering: start is accepted at edge E0. busy=1 from just after E0.
- With early exit, first differing bit at position k:
  - Decision registered at edge E(WIDTH-k).
  - done=1 and busy=0 during the following cycle.
  - Flags are valid in the same cycle as done.
- Equal operands: decision at E(WIDTH) (worst case).
- Back-to-back: start held high through the DONE cycle is accepted at the edge that ends DONE. The next compare begins with no IDLE cycle; throughput is one compare per (latency + 1) cycles.
- The values of a and b are don't-care except at the accepting edge.

## Configuration
- Macro: SERIAL_COMPARE_EARLY_EXIT_EN.
- Defined:
  - COMPARE leaves at the first differing bit.
  - Latency is data-dependent: from 1 to WIDTH cycles.
- Undefined:
  - COMPARE always runs all WIDTH bit positions; latency is fixed at WIDTH cycles.
  - The first decision sets hit=1. Later bit positions do not change the flags.
  - equal is set at idx==0 only if hit==0.
- Result values are identical in both builds; only latency differs.

## Test plan
- Greater, early MSB: WIDTH=4, a=4'b1010, b=4'b0110, start at E0.
  - With macro: greater=1 and done=1 after E1.
  - Without macro: greater=1 and done=1 after E4, and greater stays 1 with lesser=0 despite the later bits.
- Lesser on LSB: a=4'b0100, b=4'b0101 → lesser=1 and done after E4 in both builds. The flags read 0 during busy.
- Equal: a=b=4'b1011 → equal=1, greater=0, lesser=0, done after E4. The flags hold through 3 idle cycles.
- Start while busy: a=4'b0001, b=4'b0001 at E0, then start with a=4'b1111, b=4'b0000 at E1.
  - The second request is ignored; result is equal=1 at E4.
  - Holding start high through DONE starts a new compare at E5.
- Reset mid-operation: assert rst_n=0 between E1 and E2 of a compare.
  - All outputs are 0 asynchronously and state is IDLE.
  - After release, a new start with a=4'b1000, b=4'b0111 gives greater=1 after E1 (macro build).
- Sweep: WIDTH=4, all 256 (a,b) pairs in both builds.
  - Exactly one flag is high at done.
  - Flags match the unsigned relation.
  - Latency matches the rule in Timing.
